// File: rtl/inv_shift_rows_serial.sv
// Row-serial AES InvShiftRows engine.
// Accepts a 128-bit AES state as four 32-bit row beats (row1..row4) and
// re-emits each row rotated right by its row index (0..3 bytes). Two
// ping-pong banks let one block fill while the other drains, so the engine
// sustains one row per cycle in steady state.
//
// Handshake rule for both streams: a beat moves on a rising clock edge
// exactly when valid && ready are both high in the preceding cycle; valid
// never depends on ready, and in_ready depends only on registers and rst_n
// (there is no combinational path from out_ready to in_ready).
module inv_shift_rows_serial (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_row,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_row,
   output logic        out_last
);

   // Per-bank lifecycle: EMPTY while filling or idle, FULL while draining.
   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_e;

   bank_state_e bank_state_q [2];
   bank_state_e bank_state_d [2];

   logic [31:0] bank_mem [2][4];
   logic        wr_bank;
   logic        rd_bank;
   logic [1:0]  wr_cnt;
   logic [1:0]  rd_cnt;
   logic [1:0]  full;
   logic        in_fire;
   logic        out_fire;
   logic        flush;

   // Row k of the state is rotated right by k bytes; byte [31:24] is column 0.
   function automatic logic [31:0] inv_rotate(input logic [31:0] row,
                                              input logic [1:0]  idx);
      logic [31:0] res;
      case (idx)
         2'd0:    res = row;
         2'd1:    res = {row[7:0],  row[31:8]};
         2'd2:    res = {row[15:0], row[31:16]};
         default: res = {row[23:0], row[31:24]};
      endcase
      return res;
   endfunction

   assign full[0]   = (bank_state_q[0] == BANK_FULL);
   assign full[1]   = (bank_state_q[1] == BANK_FULL);
   assign flush     = !rst_n || clear;

   assign in_ready  = rst_n && !full[wr_bank];
   assign out_valid = full[rd_bank];
   assign out_row   = out_valid ? bank_mem[rd_bank][rd_cnt] : 32'h0;
   assign out_last  = out_valid && (rd_cnt == 2'd3);

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   // Bank state register; reset and clear both return every bank to EMPTY.
   always_ff @(posedge clk) begin
      if (flush) begin
         bank_state_q[0] <= BANK_EMPTY;
         bank_state_q[1] <= BANK_EMPTY;
      end else begin
         bank_state_q[0] <= bank_state_d[0];
         bank_state_q[1] <= bank_state_d[1];
      end
   end

   // Bank next-state: the 4th accepted write fills a bank, the 4th read
   // empties it. Write and read never target the same bank in one cycle
   // because writes need an EMPTY bank and reads need a FULL one.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_state_d[b] = bank_state_q[b];
         case (bank_state_q[b])
            BANK_EMPTY: begin
               if (in_fire && (wr_bank == 1'(b)) && (wr_cnt == 2'd3))
                  bank_state_d[b] = BANK_FULL;
            end
            BANK_FULL: begin
               if (out_fire && (rd_bank == 1'(b)) && (rd_cnt == 2'd3))
                  bank_state_d[b] = BANK_EMPTY;
            end
            default: bank_state_d[b] = BANK_EMPTY;
         endcase
      end
   end

   // Write side: store the rotated row and advance the fill pointer.
   always_ff @(posedge clk) begin
      if (flush) begin
         wr_bank <= 1'b0;
         wr_cnt  <= 2'd0;
      end else if (in_fire) begin
         wr_cnt <= wr_cnt + 2'd1;
         if (wr_cnt == 2'd3)
            wr_bank <= !wr_bank;
      end
   end

   // Read side: advance the drain pointer on each transferred beat; it
   // holds while the sink stalls, keeping out_row/out_last stable.
   always_ff @(posedge clk) begin
      if (flush) begin
         rd_bank <= 1'b0;
         rd_cnt  <= 2'd0;
      end else if (out_fire) begin
         rd_cnt <= rd_cnt + 2'd1;
         if (rd_cnt == 2'd3)
            rd_bank <= !rd_bank;
      end
   end

   // Bank storage; contents are zeroed on flush so stale rows never leak.
   always_ff @(posedge clk) begin
      if (flush) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < 4; r++)
               bank_mem[b][r] <= 32'h0;
      end else if (in_fire) begin
         bank_mem[wr_bank][wr_cnt] <= inv_rotate(in_row, wr_cnt);
      end
   end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Bench for inv_shift_rows_serial: table-driven known-answer blocks,
// hand-written backpressure / reset / clear sequences, and a long
// randomized run scored against a byte-array InvShiftRows model.
module tb_inv_shift_rows_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_row;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_row;
   logic        out_last;

   inv_shift_rows_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_row    (in_row),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .out_last  (out_last)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct packed {
      logic [3:0][31:0] in_rows;
      logic [3:0][31:0] exp_rows;
   } vec_t;

   vec_t        tbl [2];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [32:0] exp_q [$];
   logic [31:0] pend_q [$];

   logic        s_in_ready;
   logic        s_out_valid;
   logic        s_out_last;
   logic [31:0] s_out_row;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_row   = 32'h0;
   logic        prev_last  = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Reference InvShiftRows for one row: output column j takes input
   // column (j - k) mod 4.
   function automatic logic [31:0] ref_rot(input logic [31:0] row, input int k);
      logic [7:0] b [4];
      logic [7:0] o [4];
      for (int i = 0; i < 4; i++) b[i] = row[31-8*i -: 8];
      for (int j = 0; j < 4; j++) o[j] = b[(j - k + 4) % 4];
      return {o[0], o[1], o[2], o[3]};
   endfunction

   // Model: collect accepted rows; only a complete block produces output.
   task automatic model_accept(input logic [31:0] row);
      pend_q.push_back(row);
      if (pend_q.size() == 4) begin
         for (int k = 0; k < 4; k++)
            exp_q.push_back({(k == 3), ref_rot(pend_q[k], k)});
         pend_q.delete();
      end
   endtask

   task automatic model_flush();
      exp_q.delete();
      pend_q.delete();
      prev_stall = 1'b0;
   endtask

   // Driver: one clock cycle. Inputs change #1 after the edge, outputs are
   // sampled #1 later, the scoreboard pops on each output transfer.
   task automatic cycle(input logic iv, input logic [31:0] row, input logic ordy);
      logic [32:0] e;
      in_valid  = iv;
      in_row    = row;
      out_ready = ordy;
      #1;
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      s_out_row   = out_row;
      s_out_last  = out_last;
      if (prev_stall) begin
         check("hold_valid", {31'h0, out_valid}, 32'h1);
         check("hold_row",   out_row, prev_row);
         check("hold_last",  {31'h0, out_last}, {31'h0, prev_last});
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got %08h expected none", out_row);
         end else begin
            e = exp_q.pop_front();
            check("out_row",  out_row, e[31:0]);
            check("out_last", {31'h0, out_last}, {31'h0, e[32]});
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_row   = out_row;
      prev_last  = out_last;
      if (iv && in_ready) model_accept(row);
      @(posedge clk);
      #1;
   endtask

   task automatic feed_block(input int t, input logic ordy);
      for (int k = 0; k < 4; k++) cycle(1'b1, tbl[t].in_rows[k], ordy);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle(1'b0, 32'h0, 1'b1);
         n++;
      end
      check("drain_empty", exp_q.size(), 32'h0);
   endtask

   initial begin
      int sent;
      int cyc;
      logic iv;
      logic ordy;
      logic [31:0] r;

      tbl[0].in_rows  = {32'hA220CB2B, 32'hAFC7AB30, 32'h2F9392C0, 32'h63EB9FA0};
      tbl[0].exp_rows = {32'h20CB2BA2, 32'hAB30AFC7, 32'hC02F9392, 32'h63EB9FA0};
      tbl[1].in_rows  = {32'h9AAAE8BB, 32'hE9D2D3BA, 32'h5B3041B4, 32'h1AAB0127};
      tbl[1].exp_rows = {32'hAAE8BB9A, 32'hD3BAE9D2, 32'hB45B3041, 32'h1AAB0127};

      // Reset
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_row = 32'h0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  {31'h0, in_ready},  32'h0);
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_out_row",   out_row,            32'h0);
      check("rst_out_last",  {31'h0, out_last},  32'h0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready",  {31'h0, in_ready},  32'h1);

      // Table: basic block then back-to-back second block, continuous flow
      for (int c = 0; c < 12; c++) begin
         cycle(c < 8, (c < 8) ? tbl[c/4].in_rows[c%4] : 32'h0, 1'b1);
         if (c < 8) check("b2b_in_ready", {31'h0, s_in_ready}, 32'h1);
         if (c == 3) check("latency_pre", {31'h0, s_out_valid}, 32'h0);
         if (c >= 4) begin
            check("b2b_valid", {31'h0, s_out_valid}, 32'h1);
            check("b2b_row",   s_out_row, tbl[(c-4)/4].exp_rows[(c-4)%4]);
            check("b2b_last",  {31'h0, s_out_last}, {31'h0, ((c-4)%4 == 3)});
         end
      end
      check("b2b_empty", exp_q.size(), 32'h0);

      // Backpressure: both banks fill, in_ready drops, head row holds
      for (int c = 0; c < 8; c++) begin
         cycle(1'b1, tbl[c/4].in_rows[c%4], 1'b0);
         check("bp_in_ready_fill", {31'h0, s_in_ready}, 32'h1);
      end
      for (int c = 0; c < 3; c++) begin
         cycle(1'b0, 32'h0, 1'b0);
         check("bp_in_ready_full", {31'h0, s_in_ready}, 32'h0);
         check("bp_head_row", s_out_row, 32'h63EB9FA0);
      end
      for (int c = 0; c < 4; c++) begin
         cycle(1'b0, 32'h0, 1'b1);
         check("bp_in_ready_drain", {31'h0, s_in_ready}, 32'h0);
      end
      cycle(1'b0, 32'h0, 1'b1);
      check("bp_in_ready_back", {31'h0, s_in_ready}, 32'h1);
      drain(20);

      // Mid-operation reset: bank0 draining, bank1 half filled
      feed_block(0, 1'b0);
      cycle(1'b1, tbl[1].in_rows[0], 1'b1);
      cycle(1'b1, tbl[1].in_rows[1], 1'b1);
      in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("mid_rst_out_row",   out_row,            32'h0);
      check("mid_rst_in_ready1", {31'h0, in_ready},  32'h1);
      model_flush();
      feed_block(1, 1'b1);
      drain(20);

      // Clear together with a live input and output handshake
      feed_block(0, 1'b0);
      in_valid = 1'b1; in_row = tbl[1].in_rows[0]; out_ready = 1'b1; clear = 1'b1;
      #1;
      check("clr_both_live", {30'h0, in_ready, out_valid}, 32'h3);
      @(posedge clk);
      #1;
      clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("clr_out_valid", {31'h0, out_valid}, 32'h0);
      check("clr_in_ready",  {31'h0, in_ready},  32'h1);
      check("clr_out_row",   out_row,            32'h0);
      model_flush();
      feed_block(1, 1'b1);
      drain(20);

      // Random stalls: 1000 blocks of random rows
      sent = 0;
      cyc  = 0;
      while (sent < 4000 && cyc < 60000) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         r    = $urandom;
         cycle(iv, r, ordy);
         if (iv && s_in_ready) sent++;
         cyc++;
      end
      check("rand_all_sent", sent, 32'd4000);
      drain(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
